// File: rtl/sram_sdi_responder.sv
// Serial SRAM responder (23LC1024-style) for SPI and SDI initiators, oversampled in clk.
// Serves byte writes and prefetched sequential reads from an internal 2^ADDR_W byte RAM.
module sram_sdi_responder #(
   parameter int ADDR_W      = 10,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       sck,
   input  logic       cs,
   input  logic [1:0] d_in,
   output logic [1:0] d_out,
   output logic [1:0] d_oe,
   output logic       mode_sdi,
   output logic       cmd_err
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CMD    = 3'd1;
   localparam logic [2:0] S_ADDR   = 3'd2;
   localparam logic [2:0] S_DUMMY  = 3'd3;
   localparam logic [2:0] S_WRITE  = 3'd4;
   localparam logic [2:0] S_READ   = 3'd5;
   localparam logic [2:0] S_IGNORE = 3'd6;

   // Synchronized bundle is {cs, sck, d[1:0]}; cs resets deasserted so no false start.
   localparam logic [3:0] SYNC_RST = 4'b1000;

   logic [3:0]        sync_q [SYNC_STAGES];
   logic              sck_q, cs_q;
   logic              sck_s, cs_s;
   logic [1:0]        d_s;
   logic              cs_rise, cs_fall, sck_rise, sck_fall;

   logic [2:0]        state;
   logic              sdi_act, is_read, fetch;
   logic [ADDR_W-1:0] addr;
   logic [6:0]        shift_in;
   logic [2:0]        bit_cnt, ocnt, step, cnt_nxt, ocnt_nxt;
   logic [1:0]        addr_cnt;
   logic [7:0]        in_byte, out_sr, out_src, rd_data;
   logic              byte_done, wr_en;
   logic [7:0]        mem [0:(1<<ADDR_W)-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
         sck_q <= 1'b0;
         cs_q  <= 1'b1;
      end else begin
         sync_q[0] <= {cs, sck, d_in};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         sck_q <= sync_q[SYNC_STAGES-1][2];
         cs_q  <= sync_q[SYNC_STAGES-1][3];
      end
   end

   assign cs_s  = sync_q[SYNC_STAGES-1][3];
   assign sck_s = sync_q[SYNC_STAGES-1][2];
   assign d_s   = sync_q[SYNC_STAGES-1][1:0];

   // sck edges only count while cs is low, so a coincident cs rise always wins.
   assign cs_rise  =  cs_s & ~cs_q;
   assign cs_fall  = ~cs_s &  cs_q;
   assign sck_rise = ~cs_s &  sck_s & ~sck_q;
   assign sck_fall = ~cs_s & ~sck_s &  sck_q;

   assign step      = sdi_act ? 3'd2 : 3'd1;
   assign cnt_nxt   = bit_cnt + step;
   assign ocnt_nxt  = ocnt + step;
   assign byte_done = (cnt_nxt == 3'd0);
   assign in_byte   = sdi_act ? {shift_in[5:0], d_s} : {shift_in, d_s[0]};
   assign out_src   = (ocnt == 3'd0) ? rd_data : out_sr;
   assign wr_en     = sck_rise && (state == S_WRITE) && byte_done;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         mode_sdi <= 1'b0;
         sdi_act  <= 1'b0;
         cmd_err  <= 1'b0;
         is_read  <= 1'b0;
         fetch    <= 1'b0;
         addr     <= '0;
         shift_in <= '0;
         bit_cnt  <= '0;
         ocnt     <= '0;
         addr_cnt <= '0;
         out_sr   <= '0;
         d_out    <= '0;
         d_oe     <= '0;
      end else begin
         // NOTE: state uses non-blocking assignments so every branch sees pre-edge values.
         cmd_err <= 1'b0;
         fetch   <= 1'b0;
         if (fetch) addr <= addr + ADDR_W'(1);

         if (cs_rise) begin
            state   <= S_IDLE;
            d_oe    <= 2'b00;
            d_out   <= 2'b00;
            bit_cnt <= '0;
         end else if (cs_fall) begin
            state    <= S_CMD;
            sdi_act  <= mode_sdi;
            bit_cnt  <= '0;
            ocnt     <= '0;
            addr_cnt <= '0;
         end else if (sck_rise && state != S_IDLE && state != S_READ) begin
            shift_in <= in_byte[6:0];
            bit_cnt  <= cnt_nxt;
            if (byte_done) begin
               case (state)
                  S_CMD: begin
                     case (in_byte)
                        8'h02:   begin is_read <= 1'b0; state <= S_ADDR; end
                        8'h03:   begin is_read <= 1'b1; state <= S_ADDR; end
                        8'h3B:   begin mode_sdi <= 1'b1; state <= S_IGNORE; end
                        8'hFF:   begin mode_sdi <= 1'b0; state <= S_IGNORE; end
                        default: begin cmd_err <= 1'b1; state <= S_IGNORE; end
                     endcase
                  end
                  S_ADDR: begin
                     // Address bytes shift through addr; only the low ADDR_W bits survive.
                     addr     <= ADDR_W'({addr, in_byte});
                     addr_cnt <= addr_cnt + 2'd1;
                     if (addr_cnt == 2'd2) begin
                        if (is_read) begin
                           fetch <= 1'b1;
                           state <= sdi_act ? S_DUMMY : S_READ;
                        end else begin
                           state <= S_WRITE;
                        end
                     end
                  end
                  S_DUMMY: state <= S_READ;
                  S_WRITE: addr  <= addr + ADDR_W'(1);
                  default: ;
               endcase
            end
         end else if (sck_fall && state == S_READ) begin
            d_oe   <= sdi_act ? 2'b11 : 2'b10;
            d_out  <= sdi_act ? out_src[7:6] : {out_src[7], 1'b0};
            out_sr <= sdi_act ? {out_src[5:0], 2'b00} : {out_src[6:0], 1'b0};
            ocnt   <= ocnt_nxt;
            if (ocnt == 3'd0) fetch <= 1'b1;
         end
      end
   end

   // NOTE: the RAM array has no reset; contents are undefined until written.
   always_ff @(posedge clk) begin
      if (wr_en) mem[addr] <= in_byte;
      if (fetch) rd_data <= mem[addr];
   end

endmodule
